hazard_scoreboard_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the 32-bit MIPS core. Generates operand

---
 rtl/hazard_scoreboard_unit_if.sv | 43 ++++
 rtl/hazard_scoreboard_unit.sv | 134 +++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_unit_if.sv
// rtl/hazard_scoreboard_unit_if.sv - pipeline-side signal bundle for the hazard scoreboard unit
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  logic [FWD_STAGES-1:0]        fwd_we;
  logic [FWD_STAGES*REG_AW-1:0] fwd_rd;
  logic [REG_AW-1:0]            idex_rs;
  logic [REG_AW-1:0]            idex_rt;
  logic                         idex_memread;
  logic [REG_AW-1:0]            idex_rt_dst;
  logic [REG_AW-1:0]            ifid_rs;
  logic [REG_AW-1:0]            ifid_rt;
  logic                         ifid_is_mdu;
  logic                         jump;
  logic                         branch_taken;
  logic                         mdu_start;
  logic [REG_AW-1:0]            mdu_rd;
  logic [SELW-1:0]              fwd_sel_a;
  logic [SELW-1:0]              fwd_sel_b;
  logic                         pc_write;
  logic                         ifid_write;
  logic                         ifid_flush;
  logic                         idex_flush;
  logic                         mdu_busy;
  logic                         mdu_done;

  modport master (
    output fwd_we, fwd_rd, idex_rs, idex_rt, idex_memread, idex_rt_dst,
           ifid_rs, ifid_rt, ifid_is_mdu, jump, branch_taken, mdu_start, mdu_rd,
    input  fwd_sel_a, fwd_sel_b, pc_write, ifid_write, ifid_flush, idex_flush,
           mdu_busy, mdu_done
  );

  modport slave (
    input  fwd_we, fwd_rd, idex_rs, idex_rt, idex_memread, idex_rt_dst,
           ifid_rs, ifid_rt, ifid_is_mdu, jump, branch_taken, mdu_start, mdu_rd,
    output fwd_sel_a, fwd_sel_b, pc_write, ifid_write, ifid_flush, idex_flush,
           mdu_busy, mdu_done
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - forwarding selects, load-use/MDU stalls and flush control
module hazard_scoreboard_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int MDU_LAT    = 8
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  typedef enum logic {RUN, LD_STALL} state_t;

  state_t            state, state_nxt;
  logic [2:0]        ld_cnt, ld_cnt_nxt;
  logic [5:0]        mdu_cnt;
  logic [REG_AW-1:0] mdu_rd_q;
  logic              mdu_busy_q;
  logic              mdu_done_q;
  logic              ld_haz;
  logic              mdu_haz;
  logic              stall;
  logic [SELW-1:0]   sel_a, sel_b;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hz.fwd_we[k] && hz.fwd_rd[k*REG_AW +: REG_AW] != '0) begin
        if (hz.fwd_rd[k*REG_AW +: REG_AW] == hz.idex_rs) sel_a = SELW'(k + 1);
        if (hz.fwd_rd[k*REG_AW +: REG_AW] == hz.idex_rt) sel_b = SELW'(k + 1);
      end
    end
  end

  assign ld_haz = hz.idex_memread && (hz.idex_rt_dst != '0) &&
                  ((hz.idex_rt_dst == hz.ifid_rs) || (hz.idex_rt_dst == hz.ifid_rt));

  assign mdu_haz = mdu_busy_q && (hz.ifid_is_mdu ||
                   ((mdu_rd_q != '0) && ((mdu_rd_q == hz.ifid_rs) || (mdu_rd_q == hz.ifid_rt))));

  assign stall = ((state == RUN) && ld_haz) || (state == LD_STALL) || mdu_haz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      ld_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    case (state)
      RUN: begin
        if (ld_haz && !hz.branch_taken && (LOAD_LAT > 1)) begin
          state_nxt  = LD_STALL;
          ld_cnt_nxt = 3'(LOAD_LAT - 1);
        end
      end
      LD_STALL: begin
        if (hz.branch_taken) begin
          state_nxt  = RUN;
          ld_cnt_nxt = '0;
        end else begin
          ld_cnt_nxt = ld_cnt - 3'd1;
          if (ld_cnt == 3'd1) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt  = RUN;
        ld_cnt_nxt = '0;
      end
    endcase
  end

  // A taken branch squashes only younger instructions, so the MDU op keeps running.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_busy_q <= 1'b0;
      mdu_cnt    <= '0;
      mdu_rd_q   <= '0;
      mdu_done_q <= 1'b0;
    end else begin
      mdu_done_q <= 1'b0;
      if (mdu_busy_q) begin
        mdu_cnt <= mdu_cnt - 6'd1;
        if (mdu_cnt == 6'd1) begin
          mdu_done_q <= 1'b1;
          mdu_busy_q <= 1'b0;
        end
      end else if (hz.mdu_start) begin
        mdu_busy_q <= 1'b1;
        mdu_cnt    <= 6'(MDU_LAT - 1);
        mdu_rd_q   <= hz.mdu_rd;
      end
    end
  end

  always_comb begin
    hz.fwd_sel_a  = sel_a;
    hz.fwd_sel_b  = sel_b;
    hz.pc_write   = 1'b1;
    hz.ifid_write = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    if (reset) begin
      hz.fwd_sel_a  = '0;
      hz.fwd_sel_b  = '0;
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (hz.branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (stall) begin
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
      hz.idex_flush = 1'b1;
    end else if (hz.jump) begin
      hz.ifid_flush = 1'b1;
    end
  end

  assign hz.mdu_busy = mdu_busy_q;
  assign hz.mdu_done = mdu_done_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - randomized and directed checks against a cycle model
module tb_hazard_scoreboard_unit;
  localparam int AW = 5;
  localparam int FS = 2;
  localparam int LL = 3;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  int ld_rem;
  int mdu_age;
  int mdu_reg;
  int obs_pc, obs_ifl, obs_efl, obs_sel_a, obs_done;

  hazard_scoreboard_unit_if #(.REG_AW(AW), .FWD_STAGES(FS)) hz();

  hazard_scoreboard_unit #(.REG_AW(AW), .FWD_STAGES(FS), .LOAD_LAT(LL), .MDU_LAT(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    hz.fwd_we = '0; hz.fwd_rd = '0; hz.idex_rs = '0; hz.idex_rt = '0;
    hz.idex_memread = 1'b0; hz.idex_rt_dst = '0; hz.ifid_rs = '0; hz.ifid_rt = '0;
    hz.ifid_is_mdu = 1'b0; hz.jump = 1'b0; hz.branch_taken = 1'b0;
    hz.mdu_start = 1'b0; hz.mdu_rd = '0;
  endtask

  function automatic int fwd_src(input int r);
    for (int k = 0; k < FS; k++) begin
      int rd;
      rd = int'(hz.fwd_rd[k*AW +: AW]);
      if (hz.fwd_we[k] && rd != 0 && rd == r) return k + 1;
    end
    return 0;
  endfunction

  // Called just after a rising edge with inputs applied; checks mid-cycle, advances one cycle.
  task automatic step();
    int rs, rt, e_a, e_b, e_pc, e_iw, e_ifl, e_efl;
    bit ldh, mdu_b, mdu_d, mduh, stl;
    #3;
    rs = int'(hz.ifid_rs);
    rt = int'(hz.ifid_rt);
    ldh = hz.idex_memread && hz.idex_rt_dst != 0 &&
          (int'(hz.idex_rt_dst) == rs || int'(hz.idex_rt_dst) == rt);
    mdu_b = (mdu_age >= 1) && (mdu_age < ML);
    mdu_d = (mdu_age == ML);
    mduh = mdu_b && (hz.ifid_is_mdu || (mdu_reg != 0 && (mdu_reg == rs || mdu_reg == rt)));
    stl = (ld_rem > 0) || ldh || mduh;
    e_a = fwd_src(int'(hz.idex_rs));
    e_b = fwd_src(int'(hz.idex_rt));
    if (reset) begin
      e_a = 0; e_b = 0; e_pc = 0; e_iw = 0; e_ifl = 1; e_efl = 1;
    end else if (hz.branch_taken) begin
      e_pc = 1; e_iw = 1; e_ifl = 1; e_efl = 1;
    end else if (stl) begin
      e_pc = 0; e_iw = 0; e_ifl = 0; e_efl = 1;
    end else if (hz.jump) begin
      e_pc = 1; e_iw = 1; e_ifl = 1; e_efl = 0;
    end else begin
      e_pc = 1; e_iw = 1; e_ifl = 0; e_efl = 0;
    end
    check("fwd_sel_a", int'(hz.fwd_sel_a), e_a);
    check("fwd_sel_b", int'(hz.fwd_sel_b), e_b);
    check("pc_write", int'(hz.pc_write), e_pc);
    check("ifid_write", int'(hz.ifid_write), e_iw);
    check("ifid_flush", int'(hz.ifid_flush), e_ifl);
    check("idex_flush", int'(hz.idex_flush), e_efl);
    check("mdu_busy", int'(hz.mdu_busy), int'(mdu_b));
    check("mdu_done", int'(hz.mdu_done), int'(mdu_d));
    obs_pc = int'(hz.pc_write); obs_ifl = int'(hz.ifid_flush);
    obs_efl = int'(hz.idex_flush); obs_sel_a = int'(hz.fwd_sel_a);
    obs_done = int'(hz.mdu_done);
    if (reset) begin
      ld_rem = 0; mdu_age = 0; mdu_reg = 0;
    end else begin
      if (hz.branch_taken) ld_rem = 0;
      else if (ld_rem > 0) ld_rem = ld_rem - 1;
      else if (ldh) ld_rem = LL - 1;
      if (mdu_b) mdu_age = mdu_age + 1;
      else if (hz.mdu_start) begin
        mdu_age = 1;
        mdu_reg = int'(hz.mdu_rd);
      end else mdu_age = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    ld_rem = 0; mdu_age = 0; mdu_reg = 0;
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    step();
    check("rst_pc_write", obs_pc, 0);
    check("rst_ifid_flush", obs_ifl, 1);
    idle();

    hz.fwd_we = 2'b11; hz.fwd_rd = {5'd8, 5'd8}; hz.idex_rs = 5'd8;
    step();
    check("fwd_youngest", obs_sel_a, 1);
    hz.fwd_we = 2'b10;
    step();
    check("fwd_older", obs_sel_a, 2);
    hz.fwd_we = 2'b11; hz.fwd_rd = '0; hz.idex_rs = 5'd0;
    hz.idex_memread = 1'b1; hz.idex_rt_dst = 5'd0; hz.ifid_rs = 5'd0;
    step();
    check("fwd_reg0", obs_sel_a, 0);
    check("no_stall_reg0", obs_pc, 1);
    idle();

    n = 0;
    hz.idex_memread = 1'b1; hz.idex_rt_dst = 5'd8; hz.ifid_rs = 5'd8;
    for (int c = 0; c < 4; c++) begin
      step();
      if (obs_pc == 0 && obs_efl == 1) n++;
      hz.idex_memread = 1'b0;
    end
    check("load_stall_len", n, LL);
    idle();

    hz.mdu_start = 1'b1; hz.mdu_rd = 5'd9;
    step();
    hz.mdu_start = 1'b0; hz.ifid_rs = 5'd9;
    n = 0;
    for (int c = 1; c <= ML; c++) begin
      step();
      if (obs_pc == 0) n++;
      if (c == ML) check("mdu_done_cycle", obs_done, 1);
    end
    check("mdu_stall_len", n, ML - 1);
    idle();

    hz.idex_memread = 1'b1; hz.idex_rt_dst = 5'd4; hz.ifid_rt = 5'd4; hz.branch_taken = 1'b1;
    step();
    check("br_ld_efl", obs_efl, 1);
    check("br_ld_pc", obs_pc, 1);
    idle();
    step();
    check("br_ld_run", obs_pc, 1);

    hz.mdu_start = 1'b1; hz.mdu_rd = 5'd3;
    step();
    hz.mdu_start = 1'b0; hz.ifid_rt = 5'd3; hz.jump = 1'b1;
    step();
    check("jmp_mdu_ifl", obs_ifl, 0);
    check("jmp_mdu_pc", obs_pc, 0);
    idle();
    reset = 1'b1;
    step();
    idle();

    hz.idex_memread = 1'b1; hz.idex_rt_dst = 5'd6; hz.ifid_rs = 5'd6;
    step();
    idle();
    reset = 1'b1;
    step();
    idle();
    step();
    check("rst_ldstall_pc", obs_pc, 1);

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      hz.fwd_we = 2'($urandom);
      hz.fwd_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      hz.idex_rs = 5'($urandom_range(0, 3));
      hz.idex_rt = 5'($urandom_range(0, 3));
      hz.idex_memread = ($urandom_range(0, 2) == 0);
      hz.idex_rt_dst = 5'($urandom_range(0, 3));
      hz.ifid_rs = 5'($urandom_range(0, 3));
      hz.ifid_rt = 5'($urandom_range(0, 3));
      hz.ifid_is_mdu = ($urandom_range(0, 7) == 0);
      hz.jump = ($urandom_range(0, 7) == 0);
      hz.branch_taken = ($urandom_range(0, 7) == 0);
      hz.mdu_start = ($urandom_range(0, 5) == 0);
      hz.mdu_rd = 5'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
